// File: rtl/ahb_pkg.sv
// Purpose: shared AHB-Lite encodings and the slave response FSM state type.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } resp_state_t;

    // Little-endian lane enables. Illegal sizes fall through to a full word;
    // such transfers are errored and never reach the SRAM.
    function automatic logic [3:0] size_to_be(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << a;
            HSIZE_HALF: be = 4'b0011 << a;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// Purpose: one-entry write buffer with opportunistic drain and byte-merge read forwarding.
// Latency: load visible to forwarding next cycle; drain issued the first cycle the SRAM port is free.
// Backpressure: none; the slave guarantees the entry is empty whenever a new load can arrive.
// Ports: load_* capture a deferred write; port_busy marks cycles the SRAM port is taken;
//        drain_vld/buf_* present the drain access; rd_addr/rd_raw_dat in, rd_dat merged out.
module ahb_sram_wbuf #(
    parameter int AW = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_vld,
    input  logic [AW-1:0] load_addr,
    input  logic [3:0]    load_be,
    input  logic [31:0]   load_dat,
    input  logic          port_busy,
    output logic          drain_vld,
    output logic          buf_vld,
    output logic [AW-1:0] buf_addr,
    output logic [3:0]    buf_be,
    output logic [31:0]   buf_dat,
    input  logic [AW-1:0] rd_addr,
    input  logic [31:0]   rd_raw_dat,
    output logic [31:0]   rd_dat
);

    // Held off during reset so a pending entry is discarded, never written.
    assign drain_vld = buf_vld & ~port_busy & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_vld <= 1'b0;
        end else if (load_vld) begin
            buf_vld <= 1'b1;
        end else if (drain_vld) begin
            buf_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_vld) begin
            buf_addr <= load_addr;
            buf_be   <= load_be;
            buf_dat  <= load_dat;
        end
    end

    // The SRAM read raced the buffered write, so newer bytes come from the buffer.
    always_comb begin
        rd_dat = rd_raw_dat;
        for (int i = 0; i < 4; i++) begin
            if (buf_vld && (buf_addr == rd_addr) && buf_be[i]) begin
                rd_dat[8*i +: 8] = buf_dat[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// Purpose: AHB-Lite slave onto a 1-cycle-latency single-port SRAM; ERROR for illegal transfers.
// Latency: zero wait states for OKAY transfers; two-cycle ERROR response otherwise.
// Backpressure: HREADYOUT_O low only in the first ERROR cycle; write/read port clash absorbed by a one-entry buffer.
// Ports: AHB-Lite slave side (HSEL_I..HRESP_O) and SRAM side (mem_cs_o..mem_rdata_i).
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int          ADDR_BITS = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 HSEL_I,
    input  logic [31:0]          HADDR_I,
    input  logic [1:0]           HTRANS_I,
    input  logic [2:0]           HSIZE_I,
    input  logic                 HWRITE_I,
    input  logic [31:0]          HWDATA_I,
    input  logic                 HREADY_I,
    output logic                 HREADYOUT_O,
    output logic [31:0]          HRDATA_O,
    output logic                 HRESP_O,
    output logic                 mem_cs_o,
    output logic                 mem_we_o,
    output logic [3:0]           mem_be_o,
    output logic [ADDR_BITS-3:0] mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    input  logic [31:0]          mem_rdata_i
);

    localparam int AW = ADDR_BITS - 2;

    logic          trans_act, acc, acc_err, rd_acc, wr_acc;
    logic [3:0]    ap_be;
    logic          dp_rd, dp_wr;
    logic [AW-1:0] dp_addr;
    logic [3:0]    dp_be;
    resp_state_t   state, state_nxt;
    logic          drain_vld, buf_vld;
    logic [AW-1:0] buf_addr;
    logic [3:0]    buf_be;
    logic [31:0]   buf_dat, fwd_dat;

    // ---------------- address phase ----------------
    assign trans_act = !((HTRANS_I == HTRANS_IDLE) || (HTRANS_I == HTRANS_BUSY));
    assign acc       = HSEL_I & HREADY_I & trans_act & ~rst_i;
    assign acc_err   = acc & ((HSIZE_I > HSIZE_WORD)
                           | ((HSIZE_I == HSIZE_HALF) & HADDR_I[0])
                           | ((HSIZE_I == HSIZE_WORD) & (HADDR_I[1:0] != 2'b00))
                           | (HADDR_I[31:ADDR_BITS] != BASE_ADDR[31:ADDR_BITS]));
    assign rd_acc    = acc & ~acc_err & ~HWRITE_I;
    assign wr_acc    = acc & ~acc_err &  HWRITE_I;
    assign ap_be     = size_to_be(HSIZE_I, HADDR_I[1:0]);

    // ---------------- data phase registers ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dp_rd <= 1'b0;
            dp_wr <= 1'b0;
        end else begin
            dp_rd <= rd_acc;
            dp_wr <= wr_acc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc) begin
            dp_addr <= HADDR_I[ADDR_BITS-1:2];
            dp_be   <= ap_be;
        end
    end

    // ---------------- response FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_OKAY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = ST_OKAY;
        HREADYOUT_O = 1'b1;
        HRESP_O     = HRESP_OKAY;
        case (state)
            ST_OKAY: begin
                if (acc_err) state_nxt = ST_ERR1;
            end
            ST_ERR1: begin
                state_nxt   = ST_ERR2;
                HREADYOUT_O = 1'b0;
                HRESP_O     = HRESP_ERROR;
            end
            ST_ERR2: begin
                HRESP_O = HRESP_ERROR;
                if (acc_err) state_nxt = ST_ERR1;
            end
            default: state_nxt = ST_OKAY;
        endcase
    end

    // ---------------- write buffer ----------------
    // A write data phase defers to the buffer only when a read address phase owns the port.
    ahb_sram_wbuf #(.AW(AW)) u_wbuf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_vld   (dp_wr & rd_acc),
        .load_addr  (dp_addr),
        .load_be    (dp_be),
        .load_dat   (HWDATA_I),
        .port_busy  (rd_acc | dp_wr),
        .drain_vld  (drain_vld),
        .buf_vld    (buf_vld),
        .buf_addr   (buf_addr),
        .buf_be     (buf_be),
        .buf_dat    (buf_dat),
        .rd_addr    (dp_addr),
        .rd_raw_dat (mem_rdata_i),
        .rd_dat     (fwd_dat)
    );

    assign HRDATA_O = dp_rd ? fwd_dat : 32'h0;

    // ---------------- SRAM port: read > direct write > drain ----------------
    always_comb begin
        mem_cs_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        if (rd_acc) begin
            mem_cs_o   = 1'b1;
            mem_be_o   = ap_be;
            mem_addr_o = HADDR_I[ADDR_BITS-1:2];
        end else if (dp_wr) begin
            mem_cs_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_be_o    = dp_be;
            mem_addr_o  = dp_addr;
            mem_wdata_o = HWDATA_I;
        end else if (drain_vld) begin
            mem_cs_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_be_o    = buf_be;
            mem_addr_o  = buf_addr;
            mem_wdata_o = buf_dat;
        end
    end

    // A write's own address phase always frees the port, so the buffer is empty here.
    a_wbuf_empty_at_write: assert property (@(posedge clk_i) disable iff (rst_i) dp_wr |-> !buf_vld);

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;

    logic        clk = 1'b0;
    logic        rst, hsel, hwrite, hready, hreadyout, hresp, mem_cs, mem_we;
    logic [31:0] haddr, hwdata, hrdata, mem_wdata, mem_rdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [3:0]  mem_be;
    logic [11:0] mem_addr;
    logic        ext_wait, rst_nxt, wait_nxt;
    logic [31:0] tb_mem [0:4095];
    int          checks = 0;
    int          errors = 0;

    logic        c_rdy, c_resp, c_cs, c_we;
    logic [31:0] c_rdata, c_wdata;
    logic [3:0]  c_be;
    logic [11:0] c_addr;

    always #5 clk = ~clk;

    assign hready = hreadyout & ~ext_wait;

    ahb_sram_slave #(.ADDR_BITS(14), .BASE_ADDR(32'h0)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .HSEL_I      (hsel),
        .HADDR_I     (haddr),
        .HTRANS_I    (htrans),
        .HSIZE_I     (hsize),
        .HWRITE_I    (hwrite),
        .HWDATA_I    (hwdata),
        .HREADY_I    (hready),
        .HREADYOUT_O (hreadyout),
        .HRDATA_O    (hrdata),
        .HRESP_O     (hresp),
        .mem_cs_o    (mem_cs),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Behavioural SRAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) tb_mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= tb_mem[mem_addr];
            end
        end
    end

    // One bus cycle: drive at negedge, sample 1 time unit later, clock edge follows.
    task automatic step(input logic sel, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata);
        @(negedge clk);
        rst      = rst_nxt;
        ext_wait = wait_nxt;
        hsel     = sel;
        htrans   = sel ? 2'b10 : 2'b00;
        hwrite   = wr;
        haddr    = addr;
        hsize    = size;
        hwdata   = wdata;
        #1;
        c_rdy = hreadyout; c_resp = hresp; c_rdata = hrdata;
        c_cs = mem_cs; c_we = mem_we; c_be = mem_be; c_addr = mem_addr; c_wdata = mem_wdata;
    endtask

    task automatic idle(input logic [31:0] wdata);
        step(1'b0, 1'b0, 32'h0, 3'd0, wdata);
    endtask

    task automatic test_reset;
        rst_nxt = 1'b1;
        idle(32'h0);
        idle(32'h0);
        checks++; if (c_rdy !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b want 1", c_rdy); end
        checks++; if (c_resp !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b want 0", c_resp); end
        checks++; if (c_rdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", c_rdata); end
        checks++; if (c_cs !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", c_cs); end
        rst_nxt = 1'b0;
        idle(32'h0);
    endtask

    task automatic test_back_to_back;
        step(1'b1, 1'b1, 32'h100, 3'd2, 32'h0);
        checks++; if (c_cs !== 1'b0) begin errors++; $display("FAIL b2b_c0_cs: got %b want 0", c_cs); end
        step(1'b1, 1'b0, 32'h100, 3'd2, 32'h1122_3344);
        checks++; if ({c_rdy, c_cs, c_we, c_addr} !== {3'b110, 12'h040}) begin errors++;
            $display("FAIL b2b_c1_rdport: got rdy=%b cs=%b we=%b addr=%h want 1 1 0 040", c_rdy, c_cs, c_we, c_addr); end
        idle(32'h0);
        checks++; if (c_rdata !== 32'h1122_3344) begin errors++; $display("FAIL b2b_fwd_rdata: got %h want 11223344", c_rdata); end
        checks++; if ({c_rdy, c_cs, c_we, c_be, c_addr} !== {3'b111, 4'hF, 12'h040} || c_wdata !== 32'h1122_3344) begin errors++;
            $display("FAIL b2b_drain: got rdy=%b cs=%b we=%b be=%b addr=%h wd=%h want 1 1 1 1111 040 11223344",
                     c_rdy, c_cs, c_we, c_be, c_addr, c_wdata); end
        idle(32'h0);
        checks++; if (tb_mem[12'h040] !== 32'h1122_3344) begin errors++; $display("FAIL b2b_mem: got %h want 11223344", tb_mem[12'h040]); end
    endtask

    task automatic test_byte_write;
        step(1'b1, 1'b1, 32'h102, 3'd0, 32'h0);
        idle(32'h00AB_0000);
        checks++; if ({c_cs, c_we, c_be, c_addr} !== {2'b11, 4'b0100, 12'h040} || c_wdata !== 32'h00AB_0000) begin errors++;
            $display("FAIL byte_wr_port: got cs=%b we=%b be=%b addr=%h wd=%h want 1 1 0100 040 00ab0000",
                     c_cs, c_we, c_be, c_addr, c_wdata); end
        idle(32'h0);
        idle(32'h0);
        step(1'b1, 1'b0, 32'h100, 3'd2, 32'h0);
        idle(32'h0);
        checks++; if (c_rdata !== 32'h11AB_3344) begin errors++; $display("FAIL byte_rd: got %h want 11ab3344", c_rdata); end
    endtask

    task automatic test_alternate;
        logic rdy_all;
        rdy_all = 1'b1;
        step(1'b1, 1'b1, 32'h200, 3'd2, 32'h0);                 rdy_all &= c_rdy;
        step(1'b1, 1'b0, 32'h204, 3'd2, 32'hA0A0_A0A0);         rdy_all &= c_rdy;
        checks++; if ({c_cs, c_we, c_addr} !== {2'b10, 12'h081}) begin errors++;
            $display("FAIL alt_c1: got cs=%b we=%b addr=%h want 1 0 081", c_cs, c_we, c_addr); end
        step(1'b1, 1'b1, 32'h208, 3'd2, 32'h0);                 rdy_all &= c_rdy;
        checks++; if (c_rdata !== 32'h0) begin errors++; $display("FAIL alt_rd204: got %h want 0", c_rdata); end
        checks++; if ({c_cs, c_we, c_addr} !== {2'b11, 12'h080} || c_wdata !== 32'hA0A0_A0A0) begin errors++;
            $display("FAIL alt_c2_drain: got cs=%b we=%b addr=%h wd=%h want 1 1 080 a0a0a0a0", c_cs, c_we, c_addr, c_wdata); end
        step(1'b1, 1'b0, 32'h200, 3'd2, 32'hB0B0_B0B0);         rdy_all &= c_rdy;
        checks++; if ({c_cs, c_we, c_addr} !== {2'b10, 12'h080}) begin errors++;
            $display("FAIL alt_c3: got cs=%b we=%b addr=%h want 1 0 080", c_cs, c_we, c_addr); end
        idle(32'h0);                                            rdy_all &= c_rdy;
        checks++; if (c_rdata !== 32'hA0A0_A0A0) begin errors++; $display("FAIL alt_rd200: got %h want a0a0a0a0", c_rdata); end
        checks++; if ({c_cs, c_we, c_addr} !== {2'b11, 12'h082} || c_wdata !== 32'hB0B0_B0B0) begin errors++;
            $display("FAIL alt_c4_drain: got cs=%b we=%b addr=%h wd=%h want 1 1 082 b0b0b0b0", c_cs, c_we, c_addr, c_wdata); end
        idle(32'h0);
        checks++; if (c_cs !== 1'b0) begin errors++; $display("FAIL alt_c5_cs: got %b want 0", c_cs); end
        checks++; if (rdy_all !== 1'b1) begin errors++; $display("FAIL alt_nostall: got %b want 1", rdy_all); end
    endtask

    task automatic test_half;
        step(1'b1, 1'b1, 32'h206, 3'd1, 32'h0);
        idle(32'h5A5A_0000);
        checks++; if ({c_cs, c_we, c_be, c_addr} !== {2'b11, 4'b1100, 12'h081}) begin errors++;
            $display("FAIL half_wr: got cs=%b we=%b be=%b addr=%h want 1 1 1100 081", c_cs, c_we, c_be, c_addr); end
        step(1'b1, 1'b0, 32'h101, 3'd1, 32'h0);
        checks++; if (c_cs !== 1'b0) begin errors++; $display("FAIL half_mis_cs: got %b want 0", c_cs); end
        idle(32'h0);
        checks++; if ({c_rdy, c_resp} !== 2'b01) begin errors++; $display("FAIL half_mis_err1: got rdy=%b resp=%b want 0 1", c_rdy, c_resp); end
        idle(32'h0);
        checks++; if ({c_rdy, c_resp} !== 2'b11) begin errors++; $display("FAIL half_mis_err2: got rdy=%b resp=%b want 1 1", c_rdy, c_resp); end
        idle(32'h0);
        checks++; if (tb_mem[12'h081] !== 32'h5A5A_0000) begin errors++; $display("FAIL half_mem: got %h want 5a5a0000", tb_mem[12'h081]); end
    endtask

    task automatic test_unaligned_read;
        step(1'b1, 1'b0, 32'h4002, 3'd2, 32'h0);
        checks++; if ({c_rdy, c_resp, c_cs} !== 3'b100) begin errors++;
            $display("FAIL unal_c0: got rdy=%b resp=%b cs=%b want 1 0 0", c_rdy, c_resp, c_cs); end
        step(1'b1, 1'b0, 32'h100, 3'd2, 32'h0);
        checks++; if ({c_rdy, c_resp, c_cs} !== 3'b010 || c_rdata !== 32'h0) begin errors++;
            $display("FAIL unal_err1: got rdy=%b resp=%b cs=%b rd=%h want 0 1 0 0", c_rdy, c_resp, c_cs, c_rdata); end
        step(1'b1, 1'b0, 32'h100, 3'd2, 32'h0);
        checks++; if ({c_rdy, c_resp, c_cs, c_we} !== 4'b1110 || c_rdata !== 32'h0) begin errors++;
            $display("FAIL unal_err2: got rdy=%b resp=%b cs=%b we=%b rd=%h want 1 1 1 0 0", c_rdy, c_resp, c_cs, c_we, c_rdata); end
        idle(32'h0);
        checks++; if ({c_rdy, c_resp} !== 2'b10 || c_rdata !== 32'h11AB_3344) begin errors++;
            $display("FAIL unal_next: got rdy=%b resp=%b rd=%h want 1 0 11ab3344", c_rdy, c_resp, c_rdata); end
    endtask

    task automatic test_out_of_range_write;
        logic we_seen;
        we_seen = 1'b0;
        step(1'b1, 1'b1, 32'h4000, 3'd2, 32'h0);   we_seen |= c_we;
        idle(32'hDEAD_BEEF);                        we_seen |= c_we;
        checks++; if ({c_rdy, c_resp} !== 2'b01) begin errors++; $display("FAIL oor_err1: got rdy=%b resp=%b want 0 1", c_rdy, c_resp); end
        idle(32'h0);                                we_seen |= c_we;
        checks++; if ({c_rdy, c_resp} !== 2'b11) begin errors++; $display("FAIL oor_err2: got rdy=%b resp=%b want 1 1", c_rdy, c_resp); end
        idle(32'h0);                                we_seen |= c_we;
        checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL oor_we: got %b want 0", we_seen); end
        checks++; if (tb_mem[12'h000] !== 32'h0 || tb_mem[12'h040] !== 32'h11AB_3344) begin errors++;
            $display("FAIL oor_mem: got %h %h want 0 11ab3344", tb_mem[12'h000], tb_mem[12'h040]); end
    endtask

    task automatic test_wait_state;
        idle(32'h0);
        wait_nxt = 1'b1;
        step(1'b1, 1'b0, 32'h100, 3'd2, 32'h0);
        checks++; if (c_cs !== 1'b0) begin errors++; $display("FAIL wait_cs: got %b want 0", c_cs); end
        wait_nxt = 1'b0;
        idle(32'h0);
        checks++; if (c_rdata !== 32'h0) begin errors++; $display("FAIL wait_rdata: got %h want 0", c_rdata); end
    endtask

    task automatic test_reset_pending;
        step(1'b1, 1'b1, 32'h300, 3'd2, 32'h0);
        step(1'b1, 1'b0, 32'h304, 3'd2, 32'hCAFE_F00D);
        checks++; if ({c_cs, c_we, c_addr} !== {2'b10, 12'h0C1}) begin errors++;
            $display("FAIL rstp_c1: got cs=%b we=%b addr=%h want 1 0 0c1", c_cs, c_we, c_addr); end
        rst_nxt = 1'b1;
        idle(32'h0);
        checks++; if (c_cs !== 1'b0) begin errors++; $display("FAIL rstp_in_reset_cs: got %b want 0", c_cs); end
        rst_nxt = 1'b0;
        idle(32'h0);
        checks++; if ({c_rdy, c_resp, c_cs} !== 3'b100 || c_rdata !== 32'h0) begin errors++;
            $display("FAIL rstp_after: got rdy=%b resp=%b cs=%b rd=%h want 1 0 0 0", c_rdy, c_resp, c_cs, c_rdata); end
        idle(32'h0);
        checks++; if (c_cs !== 1'b0) begin errors++; $display("FAIL rstp_after2_cs: got %b want 0", c_cs); end
        idle(32'h0);
        checks++; if (tb_mem[12'h0C0] !== 32'h0) begin errors++; $display("FAIL rstp_mem: got %h want 0", tb_mem[12'h0C0]); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) tb_mem[i] = 32'h0;
        mem_rdata = 32'h0;
        rst = 1'b1; rst_nxt = 1'b1; ext_wait = 1'b0; wait_nxt = 1'b0;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 3'd0; hwdata = 32'h0;
        test_reset;
        test_back_to_back;
        test_byte_write;
        test_alternate;
        test_half;
        test_unaligned_read;
        test_out_of_range_write;
        test_wait_state;
        test_reset_pending;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
